// File: rtl/mem_fill_arbiter.sv
// mem_fill_arbiter: shares one pipelined memory port between the I-cache and D-cache fill FSMs
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (alternate contested grants; default: I-cache always wins)
// Ports:
//   clk, rst                   clock and synchronous active-high reset
//   i_req, i_addr              I-cache fill request and sequential fill address
//   d_req, d_addr              D-cache fill request and fill/store address
//   d_wr, d_wdata              D-cache single-cycle store request and data
//   mem_rdata                  memory read data, LATENCY cycles after issue
//   mem_addr, mem_en, mem_wr   memory address, access enable, write enable
//   mem_wdata                  memory write data
//   fill_data                  mem_rdata passed through to both caches
//   i_data_valid, d_data_valid fill_data belongs to I-cache / D-cache
//   i_wait, d_wait             requester not served this cycle
//   d_wr_ack                   store accepted this cycle
module mem_fill_arbiter #(
    parameter int LATENCY = 4,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_wr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] fill_data,
    output logic              i_data_valid,
    output logic              d_data_valid,
    output logic              i_wait,
    output logic              d_wait,
    output logic              d_wr_ack
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] I_OWN = 2'd1;
    localparam logic [1:0] D_OWN = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0]         state, state_nx;
    logic [3:0]         outstanding;
    logic [LATENCY-1:0] tag_v, tag_d;
    logic               fav_d, own_req, issue, store, retire;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic rr;
    always_ff @(posedge clk)
        if (rst)
            rr <= 1'b0;
        else if (state == IDLE && i_req && d_req)
            rr <= ~rr;
    assign fav_d = rr;
`else
    assign fav_d = 1'b0;
`endif

    always_comb begin
        own_req  = (state == I_OWN) ? i_req : d_req;
        issue    = ~rst & (state == I_OWN || state == D_OWN) & own_req;
        store    = ~rst & (state == IDLE) & d_wr & ~d_req & ~i_req;
        retire   = tag_v[LATENCY-1];
        state_nx = (state == IDLE)  ? ((i_req && d_req) ? (fav_d ? D_OWN : I_OWN) :
                                       i_req ? I_OWN : d_req ? D_OWN : IDLE) :
                   (state == DRAIN) ? ((outstanding == 4'd0) ? IDLE : DRAIN) :
                   own_req          ? state :
                   (outstanding != 4'd0) ? DRAIN : IDLE;
    end

    // Tag pipeline mirrors the memory latency; stage LATENCY-1 lines up with mem_rdata.
    always_ff @(posedge clk)
        if (rst) begin
            state       <= IDLE;
            outstanding <= 4'd0;
            tag_v       <= '0;
            tag_d       <= '0;
        end else begin
            state       <= state_nx;
            outstanding <= outstanding + {3'b000, issue} - {3'b000, retire};
            tag_v       <= LATENCY'({tag_v, issue});
            tag_d       <= LATENCY'({tag_d, state == D_OWN});
        end

    assign mem_en       = issue | store;
    assign mem_wr       = store;
    assign mem_addr     = issue ? ((state == D_OWN) ? d_addr : i_addr) : store ? d_addr : '0;
    assign mem_wdata    = store ? d_wdata : '0;
    assign fill_data    = mem_rdata;
    assign d_wr_ack     = store;
    assign i_data_valid = ~rst & retire & ~tag_d[LATENCY-1];
    assign d_data_valid = ~rst & retire & tag_d[LATENCY-1];
    assign i_wait       = ~rst & i_req & (state != I_OWN);
    // A store raised together with d_req is ignored, so d_req decides which grant counts.
    assign d_wait       = ~rst & (d_req ? (state != D_OWN) : (d_wr & ~store));
endmodule

// File: tb/tb_mem_fill_arbiter.sv
// tb_mem_fill_arbiter: directed and random checks of mem_fill_arbiter against a transaction-level model
module tb_mem_fill_arbiter;
    localparam int LAT = 4;

    logic        clk, rst, i_req, d_req, d_wr;
    logic [15:0] i_addr, d_addr, d_wdata, mem_rdata, mem_addr, mem_wdata, fill_data;
    logic        mem_en, mem_wr, i_data_valid, d_data_valid, i_wait, d_wait, d_wr_ack;

    mem_fill_arbiter #(.LATENCY(LAT), .ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .d_req(d_req), .d_addr(d_addr),
        .d_wr(d_wr), .d_wdata(d_wdata), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .fill_data(fill_data),
        .i_data_valid(i_data_valid), .d_data_valid(d_data_valid), .i_wait(i_wait),
        .d_wait(d_wait), .d_wr_ack(d_wr_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] f(input logic [15:0] a);
        return (a * 16'h9E37) ^ 16'hC3A5;
    endfunction

    // Memory: returns f(addr) LAT cycles after a read, junk otherwise.
    logic [15:0] pipe [LAT];
    always @(posedge clk) begin
        for (int k = LAT - 1; k > 0; k--) pipe[k] <= pipe[k-1];
        pipe[0] <= (mem_en && !mem_wr) ? f(mem_addr) : 16'($urandom);
    end
    assign mem_rdata = pipe[LAT-1];

    int errors = 0, checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: owner (0 none, 1 I, 2 D), drain flag and a queue of
    // responses stamped with the cycle they are due on mem_rdata.
    typedef struct {int due; bit d; logic [15:0] data;} rsp_t;
    rsp_t q[$];
    int   t = 0, own = 0, n_idv = 0;
    bit   drain = 0, fav_d = 0, g_i, g_d, g_st;

    // Fill FSM / store emulation driving the inputs.
    int          i_left = 0, d_left = 0;
    logic [15:0] i_a = 0, d_a = 0, st_a = 0, st_d = 0;
    bit          st_pend = 0;

    task automatic cyc();
        bit          iss, st, e_idv, e_ddv;
        logic [15:0] e_fd, e_addr;
        i_req   = i_left > 0;
        i_addr  = i_a;
        d_req   = d_left > 0;
        d_wr    = st_pend && !d_req;
        d_addr  = d_req ? d_a : st_a;
        d_wdata = st_pend ? st_d : 16'h0;
        @(negedge clk);
        iss = !rst && ((own == 1 && i_req) || (own == 2 && d_req));
        st  = !rst && own == 0 && !drain && d_wr && !d_req && !i_req;
        e_idv = 0; e_ddv = 0; e_fd = 0;
        foreach (q[k]) if (q[k].due == t) begin
            if (q[k].d) e_ddv = 1; else e_idv = 1;
            e_fd = q[k].data;
        end
        if (rst) begin e_idv = 0; e_ddv = 0; end
        e_addr = iss ? ((own == 2) ? d_addr : i_addr) : st ? d_addr : 16'h0;
        chk("mem_en", mem_en, iss | st);
        chk("mem_wr", mem_wr, st);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, st ? d_wdata : 16'h0);
        chk("d_wr_ack", d_wr_ack, st);
        chk("i_data_valid", i_data_valid, e_idv);
        chk("d_data_valid", d_data_valid, e_ddv);
        chk("i_wait", i_wait, !rst && i_req && own != 1);
        chk("d_wait", d_wait, !rst && (d_req ? own != 2 : (d_wr && !st)));
        chk("fill_pass", fill_data, mem_rdata);
        if (e_idv || e_ddv) chk("fill_data", fill_data, e_fd);
        if (i_data_valid) n_idv++;
        g_i  = iss && own == 1;
        g_d  = iss && own == 2;
        g_st = st;
        if (rst) begin
            own = 0; drain = 0; fav_d = 0; q.delete();
        end else begin
            int inflight = q.size();
            if (own == 0 && !drain) begin
                if (i_req && d_req) begin
                    own = fav_d ? 2 : 1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    fav_d = !fav_d;
`endif
                end else if (i_req) own = 1;
                else if (d_req) own = 2;
            end else if (drain) begin
                if (inflight == 0) drain = 0;
            end else if ((own == 1 && !i_req) || (own == 2 && !d_req)) begin
                own = 0;
                drain = inflight != 0;
            end
            while (q.size() > 0 && q[0].due == t) void'(q.pop_front());
            if (iss) q.push_back('{t + LAT, g_d, f(e_addr)});
        end
        t++;
        @(posedge clk);
        #1;
        if (g_i) begin i_a += 16'd2; i_left--; end
        if (g_d) begin d_a += 16'd2; d_left--; end
        if (g_st) st_pend = 0;
    endtask

    task automatic do_reset();
        rst = 1; i_left = 0; d_left = 0; st_pend = 0;
        cyc();
        rst = 0;
    endtask

    initial begin
        rst = 1; i_req = 0; d_req = 0; d_wr = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
        repeat (2) cyc();
        rst = 0;
        cyc();
        // 8-word I fill from 0x0100
        n_idv = 0; i_a = 16'h0100; i_left = 8;
        repeat (16) cyc();
        chk("t1_pulses", n_idv, 8);
        // Contested fill; I drops after 3 reads, D waits through the drain
        i_a = 16'h0300; i_left = 3; d_a = 16'h0400; d_left = 4;
        repeat (20) cyc();
        // Second contested round
        i_a = 16'h0600; i_left = 2; d_a = 16'h0700; d_left = 2;
        repeat (20) cyc();
        chk("t3_done", i_left + d_left, 0);
        // Store alone, then store losing to an I request
        st_pend = 1; st_a = 16'h2000; st_d = 16'hBEEF;
        cyc();
        chk("t4_store_done", st_pend, 0);
        st_pend = 1; st_a = 16'h2002; st_d = 16'h1234; i_a = 16'h0800; i_left = 2;
        repeat (14) cyc();
        chk("t4_store_late", st_pend, 0);
        // Reset in the middle of a fill drops all in-flight data
        i_a = 16'h0500; i_left = 8;
        repeat (3) cyc();
        do_reset();
        n_idv = 0;
        repeat (8) cyc();
        chk("t5_no_valid", n_idv, 0);
        // Random traffic
        repeat (600) begin
            if (i_left == 0 && $urandom_range(3) == 0) begin
                i_left = $urandom_range(8, 1); i_a = 16'($urandom);
            end
            if (d_left == 0 && !st_pend) begin
                case ($urandom_range(5))
                    0: begin d_left = $urandom_range(8, 1); d_a = 16'($urandom); end
                    1, 2: begin st_pend = 1; st_a = 16'($urandom); st_d = 16'($urandom); end
                    default: ;
                endcase
            end
            if ($urandom_range(150) == 0) do_reset();
            else cyc();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
